dvi_link_sequencer: RTL and testbench
=====================================

// Module: dvi_link_sequencer
// PURPOSE
//  Brings the DVI transmit path up and down cleanly. Watches hot-plug detect and
//  MMCM lock, holds the serializer and timing generator in reset, and releases
//  them in order. TMDS output is enabled only on a frame boundary. Sits beside the
//  display clock generator and drives the resets/enable of timing, encoder and
//  serializer blocks.
// PARAMETERS
//  DEBOUNCE_CYCLES  1024    cycles HPD must hold a new level before it is accepted
//  SER_RST_CYCLES   16      cycles serializer/timing reset held in RESET state (>=2)
//  FRAME_TIMEOUT    2000000 cycles to wait for a frame-start pulse in ALIGN (>=2)
// PORTS
//  i_clk          in   1  pixel clock; all logic in this domain
//  i_rst_n        in   1  synchronous reset, active-low
//  i_hpd          in   1  hot-plug detect, asynchronous (2-flop synchronized inside)
//  i_clk_lock     in   1  MMCM lock, asynchronous (2-flop synchronized inside)
//  i_frame        in   1  1-cycle frame-start pulse from timing generator
//  o_ser_rst      out  1  serializer reset, active-high
//  o_timing_rst   out  1  timing generator reset, active-high
//  o_tmds_en      out  1  gate for TMDS data/ctrl; 0 forces blanking
//  o_link_up      out  1  high while in ACTIVE
//  o_state        out  2  IDLE=0 RESET=1 ALIGN=2 ACTIVE=3
//  o_drop_cnt     out  8  saturating count of ACTIVE->IDLE drops
//  o_retry_cnt    out  4  saturating count of ALIGN timeouts
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge): state=IDLE, o_ser_rst=1, o_timing_rst=1,
//    o_tmds_en=0, o_link_up=0, counters=0, sync flops=0, hpd_ok=0; any state, mid-op.
//  - hpd_s, lock_s: 2-flop synchronized i_hpd / i_clk_lock.
//  - hpd_ok: debounced hpd_s. Updates only after hpd_s differs from hpd_ok for
//    DEBOUNCE_CYCLES consecutive cycles. Any glitch back clears the debounce count.
//  - link_ok = hpd_ok & lock_s.
//  - All outputs registered; Moore on state (o_ser_rst=o_timing_rst=1 in IDLE/RESET,
//    0 in ALIGN/ACTIVE; o_tmds_en=o_link_up=1 only in ACTIVE).
//  - IDLE: link_ok=1 -> RESET next cycle, cycle counter cleared.
//  - RESET: counts SER_RST_CYCLES cycles, then -> ALIGN, counter cleared.
//  - ALIGN: i_frame=1 -> ACTIVE; o_tmds_en rises the cycle after the pulse.
//    Counter reaches FRAME_TIMEOUT-1 with no pulse -> RESET, o_retry_cnt+1.
//  - ACTIVE: stays until link_ok=0.
//  - Any non-IDLE state: link_ok=0 -> IDLE next cycle. If leaving ACTIVE,
//    o_drop_cnt+1. Outputs return to reset-level values.
//  - Priority, same cycle: link loss > i_frame > timeout.
//  - Counters saturate at 8'hFF / 4'hF, never wrap; cleared only by reset.
//  - Cycle counter width = $clog2(max(SER_RST_CYCLES, FRAME_TIMEOUT))+1.
//  - i_frame ignored outside ALIGN.
// CONFIGURATION
//  DVI_SEQ_HPD_DEBOUNCE_EN defined: debounce as above.
//  Undefined: hpd_ok = hpd_s directly (synchronizer latency only).
//   DEBOUNCE_CYCLES unused; debounce counter not built.
// TESTING (DEBOUNCE_CYCLES=8, SER_RST_CYCLES=4, FRAME_TIMEOUT=100, debounce on)
//  1 Reset held 5 cycles, hpd=lock=0 -> state=0, ser_rst=timing_rst=1, tmds_en=0,
//    counts=0.
//  2 lock=1, hpd 0->1 held -> RESET 2+8+1 cycles after hpd edge. ALIGN 4 cycles later.
//    i_frame pulse -> tmds_en=1, link_up=1 next cycle.
//  3 In ACTIVE, hpd low for 5 cycles then high -> no state change, drop_cnt=0.
//    Held low 8+ cycles -> IDLE, drop_cnt=1.
//  4 In ALIGN, no i_frame for 100 cycles -> RESET, retry_cnt=1. Repeat 20x ->
//    retry_cnt=15 (saturated).
//  5 In ALIGN, lock drops in the same cycle as i_frame -> IDLE, tmds_en stays 0.
//  6 Assert i_rst_n=0 in ACTIVE with drop_cnt=3 -> next cycle all outputs at reset
//    values, drop_cnt=0.

Source files
------------

// File: rtl/dvi_link_sequencer.sv
// DVI transmit link bring-up sequencer: debounced HPD and MMCM lock gate an ordered
// release of serializer/timing resets; TMDS is enabled on a frame boundary.
// Optional HPD debounce enabled by defining DVI_SEQ_HPD_DEBOUNCE_EN.
module dvi_link_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int SER_RST_CYCLES  = 16,
    parameter int FRAME_TIMEOUT   = 2000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_hpd,
    input  logic       i_clk_lock,
    input  logic       i_frame,
    output logic       o_ser_rst,
    output logic       o_timing_rst,
    output logic       o_tmds_en,
    output logic       o_link_up,
    output logic [1:0] o_state,
    output logic [7:0] o_drop_cnt,
    output logic [3:0] o_retry_cnt
);

    localparam int MAX_CYC = (SER_RST_CYCLES > FRAME_TIMEOUT) ? SER_RST_CYCLES : FRAME_TIMEOUT;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESET  = 2'd1;
    localparam logic [1:0] ST_ALIGN  = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    logic          r_hpd_m, r_hpd_s, r_lock_m, r_lock_s;
    logic          w_hpd_ok, w_link_ok;
    logic [1:0]    r_state, w_nxt_state;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_clr, w_drop_inc, w_retry_inc;
    logic          r_ser_rst, r_timing_rst, r_tmds_en, r_link_up;
    logic [7:0]    r_drop_cnt;
    logic [3:0]    r_retry_cnt;

    // Two-flop synchronizers for the asynchronous HPD and lock inputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hpd_m  <= 1'b0;
            r_hpd_s  <= 1'b0;
            r_lock_m <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_hpd_m  <= i_hpd;
            r_hpd_s  <= r_hpd_m;
            r_lock_m <= i_clk_lock;
            r_lock_s <= r_lock_m;
        end
    end

`ifdef DVI_SEQ_HPD_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] r_db_cnt;
    logic          r_hpd_ok;

    // HPD debounce: accept a new level only after it persists; any return clears the run
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_db_cnt <= {DW{1'b0}};
            r_hpd_ok <= 1'b0;
        end else if (r_hpd_s != r_hpd_ok) begin
            if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                r_hpd_ok <= r_hpd_s;
                r_db_cnt <= {DW{1'b0}};
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end else begin
            r_db_cnt <= {DW{1'b0}};
        end
    end
    assign w_hpd_ok = r_hpd_ok;
`else
    assign w_hpd_ok = r_hpd_s;
`endif

    assign w_link_ok = w_hpd_ok & r_lock_s;

    // Next-state logic; link loss outranks frame, which outranks the align timeout
    always_comb begin
        w_nxt_state = r_state;
        w_cnt_clr   = 1'b0;
        w_drop_inc  = 1'b0;
        w_retry_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_link_ok) begin
                    w_nxt_state = ST_RESET;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_RESET: begin
                if (!w_link_ok) begin
                    w_nxt_state = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (r_cnt == CW'(SER_RST_CYCLES - 1)) begin
                    w_nxt_state = ST_ALIGN;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_nxt_state = ST_RESET;
                end
            end
            ST_ALIGN: begin
                if (!w_link_ok) begin
                    w_nxt_state = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end else if (i_frame) begin
                    w_nxt_state = ST_ACTIVE;
                    w_cnt_clr   = 1'b1;
                end else if (r_cnt == CW'(FRAME_TIMEOUT - 1)) begin
                    w_nxt_state = ST_RESET;
                    w_cnt_clr   = 1'b1;
                    w_retry_inc = 1'b1;
                end else begin
                    w_nxt_state = ST_ALIGN;
                end
            end
            ST_ACTIVE: begin
                if (!w_link_ok) begin
                    w_nxt_state = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                    w_drop_inc  = 1'b1;
                end else begin
                    w_nxt_state = ST_ACTIVE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    // State, cycle counter and saturating event counters
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CW{1'b0}};
            r_drop_cnt  <= 8'h00;
            r_retry_cnt <= 4'h0;
        end else begin
            r_state <= w_nxt_state;
            if (w_cnt_clr) begin
                r_cnt <= {CW{1'b0}};
            end else if ((r_state == ST_RESET) || (r_state == ST_ALIGN)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
            if (w_retry_inc && (r_retry_cnt != 4'hF)) begin
                r_retry_cnt <= r_retry_cnt + 4'd1;
            end else begin
                r_retry_cnt <= r_retry_cnt;
            end
        end
    end

    // Moore outputs registered from the next state so they move with r_state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ser_rst    <= 1'b1;
            r_timing_rst <= 1'b1;
            r_tmds_en    <= 1'b0;
            r_link_up    <= 1'b0;
        end else begin
            r_ser_rst    <= (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_RESET);
            r_timing_rst <= (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_RESET);
            r_tmds_en    <= (w_nxt_state == ST_ACTIVE);
            r_link_up    <= (w_nxt_state == ST_ACTIVE);
        end
    end

    assign o_ser_rst    = r_ser_rst;
    assign o_timing_rst = r_timing_rst;
    assign o_tmds_en    = r_tmds_en;
    assign o_link_up    = r_link_up;
    assign o_state      = r_state;
    assign o_drop_cnt   = r_drop_cnt;
    assign o_retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_dvi_link_sequencer.sv
// Self-checking bench for dvi_link_sequencer: directed scenarios plus randomized
// HPD/lock/frame activity, compared every cycle against a behavioural model.
module tb_dvi_link_sequencer;

    localparam int DB  = 8;
    localparam int SER = 4;
    localparam int TO  = 100;
`ifdef DVI_SEQ_HPD_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, hpd, lock, frame;
    logic       ser_rst, timing_rst, tmds_en, link_up;
    logic [1:0] state;
    logic [7:0] drop_cnt;
    logic [3:0] retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    dvi_link_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .SER_RST_CYCLES (SER),
        .FRAME_TIMEOUT  (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hpd       (hpd),
        .i_clk_lock  (lock),
        .i_frame     (frame),
        .o_ser_rst   (ser_rst),
        .o_timing_rst(timing_rst),
        .o_tmds_en   (tmds_en),
        .o_link_up   (link_up),
        .o_state     (state),
        .o_drop_cnt  (drop_cnt),
        .o_retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: time-in-state arithmetic and an HPD sample history
    bit   m_valid = 1'b0;
    int   m_edge  = 0;
    int   m_state, m_enter, m_drop, m_retry;
    bit   m_hpd_m, m_hpd_s, m_lock_m, m_lock_s, m_hpd_ok;
    bit   hist[$];

    always @(posedge clk) begin : model
        bit link, prev_hpd_s, prev_lock_s, all_diff;
        m_edge++;
        if (rst_n !== 1'b1) begin
            m_valid = 1'b1;
            m_state = 0; m_enter = m_edge; m_drop = 0; m_retry = 0;
            m_hpd_m = 0; m_hpd_s = 0; m_lock_m = 0; m_lock_s = 0; m_hpd_ok = 0;
            hist.delete();
        end else begin
            prev_hpd_s  = m_hpd_s;
            prev_lock_s = m_lock_s;
            link = (DB_EN ? m_hpd_ok : prev_hpd_s) & prev_lock_s;
            if (m_state == 0) begin
                if (link) begin m_state = 1; m_enter = m_edge; end
            end else if (!link) begin
                if (m_state == 3 && m_drop < 255) m_drop++;
                m_state = 0;
            end else if (m_state == 1 && (m_edge - m_enter) == SER) begin
                m_state = 2; m_enter = m_edge;
            end else if (m_state == 2 && frame) begin
                m_state = 3;
            end else if (m_state == 2 && (m_edge - m_enter) == TO) begin
                m_state = 1; m_enter = m_edge;
                if (m_retry < 15) m_retry++;
            end
            hist.push_back(prev_hpd_s);
            if (hist.size() > DB) void'(hist.pop_front());
            if (hist.size() == DB) begin
                all_diff = 1'b1;
                for (int i = 0; i < hist.size(); i++) if (hist[i] == m_hpd_ok) all_diff = 1'b0;
                if (all_diff) m_hpd_ok = ~m_hpd_ok;
            end
            m_hpd_s  = m_hpd_m;  m_hpd_m  = hpd;
            m_lock_s = m_lock_m; m_lock_m = lock;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin : compare
        logic [17:0] act, exp_v;
        if (m_valid) begin
            act   = {state, ser_rst, timing_rst, tmds_en, link_up, drop_cnt, retry_cnt};
            exp_v = {m_state[1:0], m_state < 2, m_state < 2, m_state == 3, m_state == 3,
                     m_drop[7:0], m_retry[3:0]};
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, act, exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (m_state != s && n < budget) begin @(negedge clk); n++; end
        check("wait_state", m_state, s);
    endtask

    task automatic bring_up();
        int n = 0;
        @(negedge clk);
        while (!(m_state == 2 || m_state == 3) && n < 500) begin @(negedge clk); n++; end
        if (m_state == 2) begin
            frame = 1'b1;
            @(negedge clk);
            frame = 1'b0;
        end
        check("bring_up_active", state, 3);
    endtask

    task automatic drop_link();
        hpd = 1'b0;
        repeat (20) @(negedge clk);
        check("drop_idle", state, 0);
        hpd = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; hpd = 1'b0; lock = 1'b0; frame = 1'b0;
        // 1: reset values
        repeat (5) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_ser", ser_rst, 1);
        check("rst_timing", timing_rst, 1);
        check("rst_tmds", tmds_en, 0);
        check("rst_counts", {drop_cnt, retry_cnt}, 0);
        rst_n = 1'b1;
        // 2: bring-up latency and frame-aligned enable
        lock = 1'b1;
        repeat (4) @(negedge clk);
        hpd = 1'b1;
        n = 0;
        while (state != 2'd1 && n < 60) begin @(posedge clk); #1; n++; end
        check("reset_latency", n, DB_EN ? 11 : 3);
        n = 0;
        while (state != 2'd2 && n < 60) begin @(posedge clk); #1; n++; end
        check("align_latency", n, SER);
        @(negedge clk) frame = 1'b1;
        @(posedge clk); #1;
        check("tmds_en_rise", tmds_en, 1);
        check("link_up_rise", link_up, 1);
        @(negedge clk) frame = 1'b0;
        // 3: short HPD glitch, then a real drop
        hpd = 1'b0;
        repeat (5) @(negedge clk);
        hpd = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_drop", drop_cnt, DB_EN ? 0 : 1);
        bring_up();
        drop_link();
        check("drop_cnt_after", drop_cnt, DB_EN ? 1 : 2);
        // 4: repeated align timeouts saturate retry count
        wait_state(2, 300);
        repeat (20 * (TO + SER) + 10) @(negedge clk);
        check("retry_sat", retry_cnt, 15);
        check("retry_tmds", tmds_en, 0);
        // 5: lock loss coincident with frame pulse
        wait_state(1, 300);
        wait_state(2, 300);
        lock = 1'b0;
        @(negedge clk);
        @(negedge clk) frame = 1'b1;
        @(negedge clk) frame = 1'b0;
        check("lockloss_state", state, 0);
        check("lockloss_tmds", tmds_en, 0);
        lock = 1'b1;
        // Randomized activity with asymmetric dwell times
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hpd)  begin if ($urandom_range(0, 149) == 0) hpd = 1'b0; end
            else      begin if ($urandom_range(0, 9) == 0)   hpd = 1'b1; end
            if (lock) begin if ($urandom_range(0, 399) == 0) lock = 1'b0; end
            else      begin if ($urandom_range(0, 4) == 0)   lock = 1'b1; end
            frame = ($urandom_range(0, 39) == 0);
        end
        frame = 1'b0; hpd = 1'b1; lock = 1'b1;
        // 6: synchronous reset in ACTIVE with drop_cnt=3
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin bring_up(); drop_link(); end
        bring_up();
        check("pre_rst_drop", drop_cnt, 3);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst6_state", state, 0);
        check("rst6_ser_timing", {ser_rst, timing_rst}, 3);
        check("rst6_tmds_link", {tmds_en, link_up}, 0);
        check("rst6_counts", {drop_cnt, retry_cnt}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
